// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: MIPS HI/LO op codes,
// controller states and small op-decoding helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSV   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request and HI/LO result bundle between the pipeline and the
// multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             abort;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, rs, rt, abort, rd_req,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, rs, rt, abort, rd_req,
    output hi, lo, busy, stall, done
  );

endinterface

// File: rtl/muldiv_addsub.sv
// WIDTH+1-bit adder/subtractor shared by shift-add multiply and restoring divide.
// cout is the carry for an add and the borrow for a subtract.
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           cout
);

  logic [WIDTH+1:0] full;

  always_comb begin
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
  end

  assign sum  = full[WIDTH:0];
  assign cout = full[WIDTH+1];

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU engine with the HI/LO registers for the EX stage.
// Operands are reduced to magnitudes on entry and the signs are re-applied in FIX.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_main_q, neg_main_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e              op;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_cout;
  logic [WIDTH:0]   mul_sel;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op    = op_e'(bus.op);
  assign sgn_a = is_signed_op(op) & bus.rs[WIDTH-1];
  assign sgn_b = is_signed_op(op) & bus.rt[WIDTH-1];
  assign mag_a = sgn_a ? -bus.rs : bus.rs;
  assign mag_b = sgn_b ? -bus.rt : bus.rt;

  // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
  assign add_a = is_div_q ? {acc_q, mq_q[WIDTH-1]} : {1'b0, acc_q};
  assign add_b = {1'b0, opnd_q};

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (is_div_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign mul_sel  = mq_q[0] ? add_sum : {1'b0, acc_q};
  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_main_q ? -prod : prod;
  assign quot_fix = neg_main_q ? -mq_q : mq_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      orig_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      opnd_q     <= opnd_d;
      orig_q     <= orig_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start && is_muldiv(op)) state_d = S_RUN;
        S_RUN:   if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d      = acc_q;
    mq_d       = mq_q;
    opnd_d     = opnd_q;
    orig_d     = orig_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (bus.abort) begin
      acc_d      = '0;
      mq_d       = '0;
      opnd_d     = '0;
      orig_d     = '0;
      cnt_d      = '0;
      is_div_d   = 1'b0;
      neg_main_d = 1'b0;
      neg_rem_d  = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && is_muldiv(op)) begin
            is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
            acc_d      = '0;
            opnd_d     = is_div_d ? mag_b : mag_a;
            mq_d       = is_div_d ? mag_a : mag_b;
            orig_d     = bus.rs;
            neg_main_d = sgn_a ^ sgn_b;
            neg_rem_d  = sgn_a;
            cnt_d      = CNT_W'(WIDTH - 1);
            busy_d     = 1'b1;
          end else if (bus.start && op == OP_MTHI) begin
            hi_d = bus.rs;
          end else if (bus.start && op == OP_MTLO) begin
            lo_d = bus.rs;
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            if (!add_cout) begin
              acc_d = add_sum[WIDTH-1:0];
              mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = add_a[WIDTH-1:0];
              mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sel[WIDTH:1];
            mq_d  = {mul_sel[0], mq_q[WIDTH-1:1]};
          end
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          // A zero divisor leaves LO all ones and returns the original dividend in HI.
          if (is_div_q && opnd_q == '0) begin
            lo_d = '1;
            hi_d = orig_q;
          end else if (is_div_q) begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO pairs are queued when an op is
// issued and popped when the done pulse appears.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [63:0] sb[$];
  op_e  rops[4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  logic [31:0] ra, rb;
  bit   sawDone;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, r64, q64, m64;
    logic [63:0] res;
    bit sgn;
    sgn = (op == OP_MULT) || (op == OP_DIV);
    sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb2 = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    res = '0;
    if (op == OP_MULT || op == OP_MULTU) begin
      r64 = sa * sb2;
      res = r64;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q64 = sa / sb2;
      m64 = sa % sb2;
      res = {m64[31:0], q64[31:0]};
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = OP_NOP;
  endtask

  task automatic waitResult(input string tag, input int expBusy, input bit stallCheck);
    int busyCycles;
    bit seen;
    logic [63:0] e;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
      if (stallCheck) checkOutput({tag, "_stall"}, {31'd0, bus.stall}, 32'd1);
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      checkOutput({tag, "_busy_cycles"}, busyCycles, expBusy);
      checkOutput({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, "_hi"}, bus.hi, e[63:32]);
        checkOutput({tag, "_lo"}, bus.lo, e[31:0]);
      end
      @(negedge clk);
      checkOutput({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = OP_NOP;
    bus.rs = '0;
    bus.rt = '0;
    bus.abort = 1'b0;
    bus.rd_req = 1'b0;
    #12;
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] signed/unsigned multiply and divide");
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    waitResult("mult_neg3x5", 33, 1'b0);
    sb.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult("multu_max", 33, 1'b0);
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitResult("div_neg7by2", 33, 1'b0);
    sb.push_back({32'h0000_0007, 32'hFFFF_FFFF});
    applyStimulus(OP_DIVU, 32'd7, 32'd0);
    waitResult("divu_by0", 33, 1'b0);
    sb.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    waitResult("div_by0", 33, 1'b0);
    sb.push_back({32'h0000_0000, 32'h8000_0000});
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult("div_ovf", 33, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i >= 2) ? $urandom_range(1, 5000) : $urandom;
      sb.push_back(model(rops[i], ra, rb));
      applyStimulus(rops[i], ra, rb);
      waitResult("rand_op", 33, 1'b0);
    end

    $display("[TB] MTHI/MTLO and MFHI stall");
    applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", bus.hi, 32'h1234_5678);
    checkOutput("mthi_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("mthi_done", {31'd0, bus.done}, 32'd0);
    applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    checkOutput("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    bus.rd_req = 1'b1;
    sb.push_back(model(OP_DIVU, 32'd1000, 32'd7));
    applyStimulus(OP_DIVU, 32'd1000, 32'd7);
    checkOutput("mfhi_old_hi", bus.hi, 32'h1234_5678);
    checkOutput("mfhi_old_lo", bus.lo, 32'h9ABC_DEF0);
    waitResult("divu_mfhi", 33, 1'b1);
    checkOutput("mfhi_stall_after", {31'd0, bus.stall}, 32'd0);
    bus.rd_req = 1'b0;

    $display("[TB] abort mid-run");
    applyStimulus(OP_MTHI, 32'h0000_000A, 32'd0);
    applyStimulus(OP_MTLO, 32'h0000_000B, 32'd0);
    applyStimulus(OP_MULTU, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_hi", bus.hi, 32'h0000_000A);
    checkOutput("abort_lo", bus.lo, 32'h0000_000B);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort_no_done", {31'd0, sawDone}, 32'd0);

    $display("[TB] start while busy");
    sb.push_back(model(OP_MULT, 32'hFFFF_FFF9, 32'd3));
    applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'd3);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.rs    = 32'h0001_2345;
    bus.rt    = 32'hFFFF_0000;
    sb.push_back(model(OP_MULT, 32'h0001_2345, 32'hFFFF_0000));
    #1;
    checkOutput("busy_start_stall", {31'd0, bus.stall}, 32'd1);
    waitResult("mult_first", 30, 1'b0);
    checkOutput("second_accepted", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    waitResult("mult_second", 33, 1'b0);

    $display("[TB] reset mid-divide");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_hi", bus.hi, 32'd0);
    checkOutput("rst_mid_lo", bus.lo, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(OP_DIV, 32'd100, 32'd7));
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    waitResult("div_after_rst", 33, 1'b0);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide unit with controller for the MIPS pipeline EX stage; sits beside the ALU.
- Sequences a single shared WIDTH-bit adder/subtractor over WIDTH cycles for MULT/MULTU/DIV/DIVU and owns the HI/LO architectural registers.
- Drives a stall request so the pipeline holds while HI/LO are pending.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 5, iteration counter width; equals clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX-stage request valid for op.
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 treated as NOP.
- rs  in  WIDTH  operand A: multiplicand/dividend; MTHI/MTLO source.
- rt  in  WIDTH  operand B: multiplier/divisor.
- abort  in  1  pipeline flush; cancels any in-flight operation.
- rd_req  in  1  MFHI/MFLO in EX needs HI/LO this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  iterative operation in flight.
- stall  out  1  = busy & (start | rd_req); pipeline holds EX while high.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi, lo, busy, done, counter, and internal working registers all 0. Reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}, abort=0:
  - Latch magnitudes of rs/rt (two's-complement abs for signed ops; raw for unsigned).
  - Latch result signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Counter = WIDTH-1; go RUN; busy=1 from the next cycle.
- IDLE, start=1, op MTHI/MTLO: hi or lo <= rs at the clock edge; no state change; done stays 0.
- IDLE, op NOP/111 or start=0: hold.
- RUN, multiply (shift-add): acc:mq pair of 2*WIDTH bits. Each cycle, if mq[0], acc += multiplicand (WIDTH+1-bit sum); then shift {carry,acc,mq} right by 1.
- RUN, divide (restoring): {rem,q} shifted left 1; trial = rem - divisor. If no borrow, rem = trial and q[0] = 1; else q[0] = 0.
- RUN counter: decrements each cycle; at 0 go FIX. RUN lasts exactly WIDTH cycles.
- FIX (1 cycle), result write:
  - Negate product/quotient/remainder per latched signs.
  - Write hi/lo: mul HI=upper, LO=lower; div LO=quotient, HI=remainder.
  - Pulse done=1; go IDLE; busy=0 from the next cycle.
- Divide by zero, decided in FIX: LO = all ones, HI = original rs, for both DIV and DIVU.
- Latency: start accepted at edge T; busy high T+1..T+WIDTH+1; hi/lo/done update at edge T+WIDTH+1. Total WIDTH+1 busy cycles.
- start while busy: not accepted; stall=1; EX holds op and operands; accepted on the first IDLE cycle.
- rd_req while busy: stall=1; hi/lo still show old values until FIX writes.
- abort, any state: next state IDLE; working registers discarded; hi/lo unchanged; no done pulse.
- abort with start in the same IDLE cycle: start ignored, including MTHI/MTLO.
- Overflow: none; signed -2^31 / -1 yields LO=0x80000000, HI=0, wrap-around accepted.
- Outputs hi, lo, busy, done are registered; stall is combinational from busy, start, and rd_req.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_NOP..OP_MTLO) and state encodings (S_IDLE, S_RUN, S_FIX).
- One natural sub-module, muldiv_addsub: the WIDTH+1-bit add/subtract with carry/borrow out, shared by both algorithms.
- Controller, counter, and HI/LO registers live in muldiv_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> after 33 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MTHI rs=0x12345678 while idle -> hi=0x12345678 next edge, busy=0. MFHI (rd_req) during a DIVU -> stall=1 every busy cycle, then 0 after done.
- abort asserted on RUN cycle 10 of MULTU 6*7 with hi/lo preloaded to 0xA/0xB -> busy=0 next cycle, hi=0xA, lo=0xB, no done. rst_n pulsed mid-DIV -> all outputs 0 immediately.
- start MULT while busy -> stall=1 and not accepted; accepted the cycle after done, second result correct.
